aibcr3_dlyline_dcc_ctrl: RTL and testbench

AIBCR3_DLYLINE_DCC_CTRL -- requirements
Module: aibcr3_dlyline_dcc_ctrl

---
 rtl/aibcr3_dcc_pkg.sv | 34 +++
 rtl/aibcr3_dcc_therm_dec.sv | 15 +
 rtl/aibcr3_dlyline_dcc_ctrl.sv | 147 ++++++++++++++
 tb/tb_aibcr3_dlyline_dcc_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and helpers for the DCC delay-line controller: one-hot FSM
// states, step direction, and the code clamp/compare functions.
package aibcr3_dcc_pkg;

   // Widest delay code supported (NUM_CELLS up to 64 needs 7 bits).
   localparam int unsigned CODE_MAX_W = 7;
   localparam int unsigned CNT_W      = 4;

   typedef logic [CODE_MAX_W-1:0] code_t;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_STEP   = 4'b0010,
      ST_SETTLE = 4'b0100,
      ST_DONE   = 4'b1000
   } state_e;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   function automatic code_t clamp_code(input code_t code, input code_t limit);
      return (code > limit) ? limit : code;
   endfunction

   function automatic dir_e step_dir(input code_t cur, input code_t tgt);
      if (tgt > cur)      return DIR_UP;
      else if (tgt < cur) return DIR_DOWN;
      else                return DIR_HOLD;
   endfunction

endpackage

// File: rtl/aibcr3_dcc_therm_dec.sv
// Binary-to-thermometer decoder for the DCC delay-cell break controls:
// therm[i] is set for every cell index below code. Purely combinational.
module aibcr3_dcc_therm_dec #(
   parameter int unsigned NUM_CELLS = 16,
   parameter int unsigned CODE_W    = $clog2(NUM_CELLS + 1)
) (
   input  logic [CODE_W-1:0]    code,
   output logic [NUM_CELLS-1:0] therm
);

   for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
      assign therm[i] = (code > CODE_W'(i));
   end

endmodule

// File: rtl/aibcr3_dlyline_dcc_ctrl.sv
// DCC delay-line controller: walks the applied delay code one cell at a time
// toward an accepted target, settling between steps. Optional macro
// AIBCR3_DCC_DIRECT_LOAD_EN adds a direct_load input that jumps straight there.
module aibcr3_dlyline_dcc_ctrl
   import aibcr3_dcc_pkg::*;
#(
   parameter int unsigned NUM_CELLS  = 16,
   parameter int unsigned CODE_W     = $clog2(NUM_CELLS + 1),
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned RESET_CODE = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CODE_W-1:0]    target_code,
   input  logic                 target_vld,
`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
   input  logic                 direct_load,
`endif
   output logic                 target_rdy,
   output logic [NUM_CELLS-1:0] bk,
   output logic [CODE_W-1:0]    cur_code,
   output logic                 busy,
   output logic                 done
);

   if (NUM_CELLS < 2 || NUM_CELLS > 64) begin : g_bad_num_cells
      $error("NUM_CELLS must be in 2..64");
   end
   if (CODE_W > CODE_MAX_W || (2 ** CODE_W) <= NUM_CELLS) begin : g_bad_code_w
      $error("CODE_W must hold 0..NUM_CELLS and fit in CODE_MAX_W");
   end
   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("SETTLE_CYC must be in 1..15");
   end
   if (RESET_CODE > NUM_CELLS) begin : g_bad_reset_code
      $error("RESET_CODE must not exceed NUM_CELLS");
   end

   localparam logic [CODE_W-1:0] RST_CODE = CODE_W'(RESET_CODE);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC);

   state_e                state_q, state_d;
   logic [CODE_W-1:0]     cur_code_q, cur_code_d;
   logic [CODE_W-1:0]     tgt_q, tgt_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_CELLS-1:0]  bk_q, bk_d;
   logic [NUM_CELLS-1:0]  bk_rst;

   logic [CODE_W-1:0]     tgt_clamped;
   dir_e                  dir;
   logic                  accept;

   assign tgt_clamped = CODE_W'(clamp_code(CODE_MAX_W'(target_code), CODE_MAX_W'(NUM_CELLS)));
   assign dir         = step_dir(CODE_MAX_W'(cur_code_q), CODE_MAX_W'(tgt_q));

   assign target_rdy  = (state_q == ST_IDLE) && !reset;
   assign accept      = target_vld && target_rdy;
   assign busy        = (state_q == ST_STEP) || (state_q == ST_SETTLE);
   assign done        = (state_q == ST_DONE);
   assign cur_code    = cur_code_q;
   assign bk          = bk_q;

   // bk is decoded from the next code so it registers on the same edge as cur_code.
   aibcr3_dcc_therm_dec #(
      .NUM_CELLS (NUM_CELLS),
      .CODE_W    (CODE_W)
   ) u_therm_next (
      .code  (cur_code_d),
      .therm (bk_d)
   );

   aibcr3_dcc_therm_dec #(
      .NUM_CELLS (NUM_CELLS),
      .CODE_W    (CODE_W)
   ) u_therm_rst (
      .code  (RST_CODE),
      .therm (bk_rst)
   );

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cur_code_d = cur_code_q;
      tgt_d      = tgt_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tgt_d = tgt_clamped;
`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
               if (direct_load) begin
                  cur_code_d = tgt_clamped;
                  state_d    = ST_DONE;
               end else
`endif
               if (tgt_clamped == cur_code_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_STEP;
               end
            end
         end

         ST_STEP: begin
            case (dir)
               DIR_UP:   cur_code_d = cur_code_q + CODE_W'(1);
               DIR_DOWN: cur_code_d = cur_code_q - CODE_W'(1);
               default:  cur_code_d = cur_code_q;
            endcase
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = (cur_code_q == tgt_q) ? ST_DONE : ST_STEP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_code_q <= RST_CODE;
         tgt_q      <= RST_CODE;
         cnt_q      <= '0;
         bk_q       <= bk_rst;
      end else begin
         state_q    <= state_d;
         cur_code_q <= cur_code_d;
         tgt_q      <= tgt_d;
         cnt_q      <= cnt_d;
         bk_q       <= bk_d;
      end
   end

endmodule

// File: tb/tb_aibcr3_dlyline_dcc_ctrl.sv
// Self-checking bench for aibcr3_dlyline_dcc_ctrl (NUM_CELLS=16, SETTLE_CYC=2):
// table-driven walks with a done-time scoreboard plus reset and jump sequences.
module tb_aibcr3_dlyline_dcc_ctrl;

   localparam int NC = 16;
   localparam int S  = 2;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] target_code;
   logic          target_vld;
   logic          target_rdy;
   logic [NC-1:0] bk;
   logic [CW-1:0] cur_code;
   logic          busy;
   logic          done;
`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
   logic          direct_load;
`endif

   always #5 clk = ~clk;

   aibcr3_dlyline_dcc_ctrl #(
      .NUM_CELLS  (NC),
      .CODE_W     (CW),
      .SETTLE_CYC (S),
      .RESET_CODE (0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .target_code (target_code),
      .target_vld  (target_vld),
`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
      .direct_load (direct_load),
`endif
      .target_rdy  (target_rdy),
      .bk          (bk),
      .cur_code    (cur_code),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      int            tgt;
      int            code;
      logic [NC-1:0] bk;
      int            cycles;
      int            busy;
   } vec_t;

   vec_t    vecs[8];
   vec_t    sb_q[$];
   int      checks = 0;
   int      errors = 0;
   bit      mon_en = 1'b0;
   bit      dl_active = 1'b0;
   logic [NC-1:0] prev_bk = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NC-1:0] therm_m(input int c);
      logic [NC-1:0] r;
      for (int i = 0; i < NC; i++) r[i] = (i < c);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Continuous invariants, sampled on the falling edge away from state updates.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("bk_is_therm_of_code", bk, therm_m(int'(cur_code)));
         check("code_le_num_cells", cur_code <= CW'(NC), 1);
         if (!dl_active) check("bk_hamming_le_1", $countones(bk ^ prev_bk) <= 1, 1);
      end
      prev_bk = bk;
   end

   task automatic run_vec(input vec_t v, input bit poke);
      int            cyc;
      int            busy_cnt;
      int            last_chg;
      int            diff;
      logic [CW-1:0] prev_code;
      vec_t          e;
      for (int i = 0; i < 20 && !target_rdy; i++) tick();
      check("rdy_before_accept", target_rdy, 1);
      target_code = CW'(v.tgt);
      target_vld  = 1'b1;
      prev_code   = cur_code;
      sb_q.push_back(v);
      tick();
      target_vld = 1'b0;
      check("code_held_at_accept", cur_code, prev_code);
      cyc      = 1;
      busy_cnt = 0;
      last_chg = 0;
      while (!done && cyc < 200) begin
         check("rdy_low_in_walk", target_rdy, 0);
         if (busy) busy_cnt++;
         if (poke) begin
            if (cyc == 3) begin
               target_code = CW'(9);
               target_vld  = 1'b1;
            end else begin
               target_vld = 1'b0;
            end
         end
         tick();
         cyc++;
         if (cur_code !== prev_code) begin
            diff = int'(cur_code) - int'(prev_code);
            check("step_size_one", (diff == 1) || (diff == -1), 1);
            check("step_spacing", cyc - last_chg, (last_chg == 0) ? 2 : 1 + S);
            last_chg  = cyc;
            prev_code = cur_code;
         end
      end
      target_vld = 1'b0;
      check("done_within_budget", done, 1);
      check("busy_low_at_done", busy, 0);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("code_at_done", cur_code, e.code);
         check("bk_at_done", bk, e.bk);
         check("cycles_to_done", cyc, e.cycles);
         check("busy_cycle_count", busy_cnt, e.busy);
      end
      tick();
      check("done_one_cycle", done, 0);
      check("rdy_after_done", target_rdy, 1);
      check("code_stable_after_done", cur_code, e.code);
   endtask

   initial begin
      // {target, final code, bk at done, cycles accept->done, busy cycles}
      vecs[0] = '{tgt: 5,  code: 5,  bk: 16'h001F, cycles: 16, busy: 15};
      vecs[1] = '{tgt: 2,  code: 2,  bk: 16'h0003, cycles: 10, busy: 9};
      vecs[2] = '{tgt: 31, code: 16, bk: 16'hFFFF, cycles: 43, busy: 42};
      vecs[3] = '{tgt: 16, code: 16, bk: 16'hFFFF, cycles: 1,  busy: 0};
      vecs[4] = '{tgt: 0,  code: 0,  bk: 16'h0000, cycles: 49, busy: 48};
      vecs[5] = '{tgt: 0,  code: 0,  bk: 16'h0000, cycles: 1,  busy: 0};
      vecs[6] = '{tgt: 1,  code: 1,  bk: 16'h0001, cycles: 4,  busy: 3};
      vecs[7] = '{tgt: 17, code: 16, bk: 16'hFFFF, cycles: 46, busy: 45};

      reset       = 1'b1;
      target_code = '0;
      target_vld  = 1'b0;
`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
      direct_load = 1'b0;
`endif
      tick();
      tick();
      check("rst_cur_code", cur_code, 0);
      check("rst_bk", bk, 16'h0000);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_target_rdy", target_rdy, 0);
      reset = 1'b0;
      tick();
      check("rdy_first_clock", target_rdy, 1);
      mon_en = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i == 0);

      // Reset during SETTLE of a 0->8 walk aborts with no done pulse.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      target_code = CW'(8);
      target_vld  = 1'b1;
      tick();
      target_vld = 1'b0;
      tick();
      check("mid_walk_code", cur_code, 1);
      check("mid_walk_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("abort_cur_code", cur_code, 0);
      check("abort_bk", bk, 16'h0000);
      check("abort_busy", busy, 0);
      check("abort_rdy", target_rdy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_done", done, 0);
      end
      reset = 1'b0;
      tick();
      check("rdy_after_release", target_rdy, 1);
      check("no_done_after_release", done, 0);
      check("code_after_release", cur_code, 0);

      run_vec('{tgt: 3, code: 3, bk: 16'h0007, cycles: 10, busy: 9}, 1'b0);

`ifdef AIBCR3_DCC_DIRECT_LOAD_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      dl_active   = 1'b1;
      target_code = CW'(12);
      direct_load = 1'b1;
      target_vld  = 1'b1;
      tick();
      target_vld  = 1'b0;
      direct_load = 1'b0;
      check("dl_cur_code", cur_code, 12);
      check("dl_bk", bk, 16'h0FFF);
      check("dl_done", done, 1);
      check("dl_busy", busy, 0);
      tick();
      check("dl_done_one_cycle", done, 0);
      check("dl_rdy", target_rdy, 1);
`endif

      check("scoreboard_empty", sb_q.size(), 0);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
